// File: rtl/dma_ctrl.sv
// CPU-facing register block for the video/RAM DMA engine: holds the transfer
// registers, issues the start handshake and halts the CPU until the transfer ends.
module dma_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        cs,
    input  logic        we,
    input  logic [2:0]  reg_sel,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic [7:0]  ctrl,
    output logic [15:0] src_addr,
    output logic [15:0] dst_addr,
    output logic [7:0]  length,
    input  logic        dma_busy,
    output logic        cpu_rdy,
    output logic        dma_err
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, REQ, RUN, FIN} state_t;

    state_t          state, state_nxt;
    logic [7:0]      src_lo, src_hi, dst_lo, dst_hi, len_q;
    logic [6:0]      ctrl_lo;
    logic            start_q, start_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            cpu_rdy_q, cpu_rdy_nxt;
    logic            err_q, err_nxt;
    logic            done_q, done_nxt;
    logic            wr_idle, rd_ctrl, go, busy;

    assign wr_idle = cs & we & rdy & (state == IDLE);
    assign rd_ctrl = cs & ~we & rdy & (reg_sel == 3'd5);
    assign go      = wr_idle & (reg_sel == 3'd5) & cpu_din[7];
    assign busy    = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/status next values
    always_comb begin
        state_nxt   = state;
        start_nxt   = start_q;
        cnt_nxt     = cnt;
        cpu_rdy_nxt = cpu_rdy_q;
        err_nxt     = err_q;
        done_nxt    = done_q;
        if (rd_ctrl) begin
            err_nxt  = 1'b0;
            done_nxt = 1'b0;
        end
        case (state)
            IDLE: begin
                if (go) begin
                    err_nxt     = 1'b0;
                    done_nxt    = 1'b0;
                    cpu_rdy_nxt = 1'b0;
                    cnt_nxt     = '0;
                    if (len_q == 8'h00) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = REQ;
                        start_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dma_busy) begin
                    start_nxt = 1'b0;
                    state_nxt = RUN;
                end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                    start_nxt = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = FIN;
                end else if (cnt != {CW{1'b1}}) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!dma_busy) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                // done reports a successful completion; a timed-out start leaves only dma_err
                if (!err_q) begin
                    done_nxt = 1'b1;
                end
                cpu_rdy_nxt = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= 1'b0;
            cnt       <= '0;
            cpu_rdy_q <= 1'b1;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else if (rdy) begin
            start_q   <= start_nxt;
            cnt       <= cnt_nxt;
            cpu_rdy_q <= cpu_rdy_nxt;
            err_q     <= err_nxt;
            done_q    <= done_nxt;
        end
    end

    // CPU-written registers, writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_lo  <= 8'h00;
            src_hi  <= 8'h00;
            dst_lo  <= 8'h00;
            dst_hi  <= 8'h00;
            len_q   <= 8'h00;
            ctrl_lo <= 7'h00;
        end else if (wr_idle) begin
            case (reg_sel)
                3'd0:    src_lo  <= cpu_din;
                3'd1:    src_hi  <= cpu_din;
                3'd2:    dst_lo  <= cpu_din;
                3'd3:    dst_hi  <= cpu_din;
                3'd4:    len_q   <= cpu_din;
                3'd5:    ctrl_lo <= cpu_din[6:0];
                default: ;
            endcase
        end
    end

    // Read mux
    always_comb begin
        cpu_dout = 8'h00;
        case (reg_sel)
            3'd0:    cpu_dout = src_lo;
            3'd1:    cpu_dout = src_hi;
            3'd2:    cpu_dout = dst_lo;
            3'd3:    cpu_dout = dst_hi;
            3'd4:    cpu_dout = len_q;
            3'd5:    cpu_dout = {busy, ctrl_lo[6:2], err_q, done_q};
            default: cpu_dout = 8'h00;
        endcase
    end

    assign ctrl     = {start_q, ctrl_lo};
    assign src_addr = {src_hi, src_lo};
    assign dst_addr = {dst_hi, dst_lo};
    assign length   = len_q;
    assign cpu_rdy  = cpu_rdy_q;
    assign dma_err  = err_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with a dma_busy engine model and an expected-value queue.
module tb_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        cs;
    logic        we;
    logic [2:0]  reg_sel;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic [7:0]  ctrl;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  length;
    logic        dma_busy;
    logic        cpu_rdy;
    logic        dma_err;

    int checks = 0;
    int errors = 0;
    string       tag_q[$];
    logic [15:0] exp_q[$];

    logic model_on = 1'b0;
    logic model_active = 1'b0;
    int   busy_cyc = 4;

    dma_ctrl #(.ACK_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .cs(cs), .we(we), .reg_sel(reg_sel),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .ctrl(ctrl), .src_addr(src_addr),
        .dst_addr(dst_addr), .length(length), .dma_busy(dma_busy), .cpu_rdy(cpu_rdy),
        .dma_err(dma_err)
    );

    always #5 clk = ~clk;

    // Engine model: raises busy half a cycle after seeing a start request
    initial begin
        dma_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_on && ctrl[7] && !model_active) begin
                model_active = 1'b1;
                dma_busy = 1'b1;
                repeat (busy_cyc) @(negedge clk);
                dma_busy = 1'b0;
                model_active = 1'b0;
            end
        end
    end

    task automatic expect_v(input string tag, input logic [15:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_v(input logic [15:0] obs);
        string t;
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %h", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; reg_sel = sel; cpu_din = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd_ctrl();
        cs = 1'b1; we = 1'b0; reg_sel = 3'd5;
        tick();
        cs = 1'b0;
    endtask

    task automatic peek(input logic [2:0] sel, output logic [7:0] v);
        reg_sel = sel;
        #1;
        v = cpu_dout;
    endtask

    task automatic wait_cpu_rdy(input int max, output int n);
        n = 0;
        while (cpu_rdy !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    logic [7:0] d;
    int n;
    int k, k_ctrl, k_rdy;

    initial begin
        rst_n = 1'b0; rdy = 1'b1; cs = 1'b0; we = 1'b0; reg_sel = 3'd0; cpu_din = 8'h00;
        #12;
        // Reset state
        expect_v("rst_ctrl", 16'h0000); expect_v("rst_cpu_rdy", 16'h0001);
        expect_v("rst_err", 16'h0000); expect_v("rst_stat", 16'h0000);
        check_v(16'(ctrl)); check_v(16'(cpu_rdy)); check_v(16'(dma_err));
        peek(3'd5, d); check_v(16'(d));
        rst_n = 1'b1;
        tick();

        // Normal transfer, with a write attempt during RUN
        model_on = 1'b1; busy_cyc = 4;
        wr(3'd0, 8'h34); wr(3'd1, 8'h12); wr(3'd2, 8'h00); wr(3'd3, 8'h40); wr(3'd4, 8'h02);
        expect_v("src", 16'h1234); expect_v("dst", 16'h4000); expect_v("len", 16'h0002);
        check_v(src_addr); check_v(dst_addr); check_v(16'(length));
        wr(3'd5, 8'h80);
        expect_v("s1_start_ctrl", 16'h0080); expect_v("s1_start_cpu_rdy", 16'h0000);
        check_v(16'(ctrl)); check_v(16'(cpu_rdy));
        tick();
        expect_v("s1_run_ctrl", 16'h0000); expect_v("s1_run_stat", 16'h0080);
        check_v(16'(ctrl)); peek(3'd5, d); check_v(16'(d));
        wr(3'd0, 8'hAA);
        expect_v("s4_src_locked", 16'h1234);
        check_v(src_addr);
        tick(); tick();
        expect_v("s1_busy_hi", 16'h0001); expect_v("s1_rdy_lo", 16'h0000);
        check_v(16'(dma_busy)); check_v(16'(cpu_rdy));
        tick();
        expect_v("s1_fin_busy", 16'h0000); expect_v("s1_fin_rdy", 16'h0000);
        check_v(16'(dma_busy)); check_v(16'(cpu_rdy));
        tick();
        expect_v("s1_done_rdy", 16'h0001); expect_v("s1_done_stat", 16'h0001);
        check_v(16'(cpu_rdy)); peek(3'd5, d); check_v(16'(d));
        wr(3'd0, 8'hAA);
        expect_v("s4_src_after", 16'h12AA);
        check_v(src_addr);
        rd_ctrl();
        expect_v("s1_clear_stat", 16'h0000);
        peek(3'd5, d); check_v(16'(d));

        // Zero length: no start, one FIN cycle
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h80);
        expect_v("s2_ctrl", 16'h0000); expect_v("s2_fin_rdy", 16'h0000); expect_v("s2_fin_stat", 16'h0080);
        check_v(16'(ctrl)); check_v(16'(cpu_rdy)); peek(3'd5, d); check_v(16'(d));
        tick();
        expect_v("s2_rdy", 16'h0001); expect_v("s2_done", 16'h0001);
        check_v(16'(cpu_rdy)); peek(3'd5, d); check_v(16'(d));
        rd_ctrl();

        // Start timeout with no busy response
        model_on = 1'b0;
        wr(3'd4, 8'h02);
        wr(3'd5, 8'h80);
        repeat (7) tick();
        expect_v("s3_ctrl_held", 16'h0080); expect_v("s3_err_lo", 16'h0000);
        check_v(16'(ctrl)); check_v(16'(dma_err));
        tick();
        expect_v("s3_ctrl_drop", 16'h0000); expect_v("s3_err", 16'h0001); expect_v("s3_fin_stat", 16'h0082);
        check_v(16'(ctrl)); check_v(16'(dma_err)); peek(3'd5, d); check_v(16'(d));
        tick();
        expect_v("s3_after_stat", 16'h0002); expect_v("s3_rdy", 16'h0001);
        peek(3'd5, d); check_v(16'(d)); check_v(16'(cpu_rdy));
        rd_ctrl();
        expect_v("s3_clear_stat", 16'h0000);
        peek(3'd5, d); check_v(16'(d));

        // Half-rate transfer and half-rate timeout
        for (int pass = 0; pass < 2; pass++) begin
            model_on = (pass == 0);
            rdy = 1'b1;
            wr(3'd5, 8'h80);
            k_ctrl = 0; k_rdy = 0; k = 0;
            rdy = 1'b0;
            while (k_rdy == 0 && k < 40) begin
                tick();
                k++;
                if (k_ctrl == 0 && ctrl[7] == 1'b0) k_ctrl = k;
                if (cpu_rdy == 1'b1) k_rdy = k;
                rdy = ((k + 1) % 2 == 0);
            end
            rdy = 1'b1;
            if (pass == 0) begin
                expect_v("s5_ctrl_drop", 16'd2); expect_v("s5_rdy_back", 16'd8);
            end else begin
                expect_v("s5_to_ctrl_drop", 16'd16); expect_v("s5_to_rdy_back", 16'd18);
            end
            check_v(16'(k_ctrl)); check_v(16'(k_rdy));
            rd_ctrl();
        end

        // Async reset mid-RUN, then a fresh transfer
        model_on = 1'b1;
        wr(3'd5, 8'h80);
        tick();
        #1 rst_n = 1'b0;
        #1;
        expect_v("s6_ctrl", 16'h0000); expect_v("s6_src", 16'h0000); expect_v("s6_len", 16'h0000);
        expect_v("s6_cpu_rdy", 16'h0001); expect_v("s6_stat", 16'h0000);
        check_v(16'(ctrl)); check_v(src_addr); check_v(16'(length)); check_v(16'(cpu_rdy));
        peek(3'd5, d); check_v(16'(d));
        tick();
        rst_n = 1'b1;
        n = 0;
        while (model_active && n < 20) begin tick(); n++; end
        tick();
        wr(3'd4, 8'h01);
        wr(3'd5, 8'h80);
        expect_v("s6_restart_ctrl", 16'h0080);
        check_v(16'(ctrl));
        wait_cpu_rdy(20, n);
        expect_v("s6_restart_cycles", 16'd6); expect_v("s6_restart_stat", 16'h0001);
        check_v(16'(n)); peek(3'd5, d); check_v(16'(d));

        // Clearing read on the FIN clk loses to the done set; plain ctrl bits
        model_on = 1'b0;
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h80);
        rd_ctrl();
        expect_v("s7_set_wins", 16'h0001);
        peek(3'd5, d); check_v(16'(d));
        wr(3'd5, 8'h7C);
        expect_v("s7_ctrl_out", 16'h007C); expect_v("s7_stat", 16'h007D); expect_v("s7_rdy", 16'h0001);
        check_v(16'(ctrl)); peek(3'd5, d); check_v(16'(d)); check_v(16'(cpu_rdy));
        expect_v("s7_sel6", 16'h0000);
        peek(3'd6, d); check_v(16'(d));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
